maxnet_controller: RTL and testbench

//  FSM that sequences the 4-neuron Maxnet DataPath: loads epsilon and initial activations, then fires PLU rounds.

---
 rtl/maxnet_controller.sv | 191 +++++++++++++++++++
 tb/tb_maxnet_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-neuron Maxnet datapath: loads epsilon and the initial activations,
// then repeats PLU rounds until a winner appears or the run is bounded by overflow, iteration limit or timeout.
module maxnet_controller #(
    parameter int MAX_ITER    = 64,
    parameter int ITER_W      = 7,
    parameter int PLU_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic              plu_done,
    input  logic              finish,
    input  logic              overflow,
    output logic              rst_plu,
    output logic              eps_reg_we,
    output logic              we_prim,
    output logic              we_a_reg,
    output logic              mux_sel,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(PLU_TIMEOUT);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_OVERFLOW = 2'b01;
    localparam logic [1:0] ST_ITER_LIM = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT_PLU,
        CHECK,
        UPDATE,
        FIN
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        status_reg, status_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;

    logic rst_plu_reg, rst_plu_next;
    logic eps_we_reg, eps_we_next;
    logic we_prim_reg, we_prim_next;
    logic we_a_reg_reg, we_a_reg_next;
    logic mux_sel_reg, mux_sel_next;
    logic start_reg, start_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            status_reg   <= ST_OK;
            iter_reg     <= '0;
            tmo_reg      <= '0;
            rst_plu_reg  <= 1'b1;
            eps_we_reg   <= 1'b0;
            we_prim_reg  <= 1'b0;
            we_a_reg_reg <= 1'b0;
            mux_sel_reg  <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            status_reg   <= status_next;
            iter_reg     <= iter_next;
            tmo_reg      <= tmo_next;
            rst_plu_reg  <= rst_plu_next;
            eps_we_reg   <= eps_we_next;
            we_prim_reg  <= we_prim_next;
            we_a_reg_reg <= we_a_reg_next;
            mux_sel_reg  <= mux_sel_next;
            start_reg    <= start_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        status_next = status_reg;
        iter_next   = iter_reg;
        tmo_next    = tmo_reg;

        case (state_reg)
            IDLE: begin
                if (go && !abort) begin
                    iter_next   = '0;
                    status_next = ST_OK;
                    state_next  = LOAD;
                end
            end
            LOAD: state_next = ARM;
            ARM: begin
                tmo_next   = '0;
                state_next = WAIT_PLU;
            end
            WAIT_PLU: begin
                // Counter parks at the limit rather than wrapping.
                tmo_next = (tmo_reg == TMO_LIMIT) ? tmo_reg : tmo_reg + TMO_W'(1);
                if (plu_done && overflow) begin
                    status_next = ST_OVERFLOW;
                    state_next  = FIN;
                end else if (plu_done) begin
                    state_next = CHECK;
                end else if (tmo_reg == TMO_LIMIT) begin
                    status_next = ST_TIMEOUT;
                    state_next  = FIN;
                end
            end
            CHECK: begin
                iter_next = (iter_reg == MAX_ITER_C) ? iter_reg : iter_reg + ITER_W'(1);
                if (finish) begin
                    status_next = ST_OK;
                    state_next  = FIN;
                end else if ((iter_reg + ITER_W'(1)) == MAX_ITER_C) begin
                    status_next = ST_ITER_LIM;
                    state_next  = FIN;
                end else begin
                    state_next = UPDATE;
                end
            end
            UPDATE:  state_next = ARM;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort freezes the run results in place and drops straight to IDLE.
        if (abort && state_reg != IDLE) begin
            state_next  = IDLE;
            status_next = status_reg;
            iter_next   = iter_reg;
        end
    end

    // Outputs are decoded from the next state so the registered pins match the state being entered.
    always_comb begin
        rst_plu_next  = 1'b0;
        eps_we_next   = 1'b0;
        we_prim_next  = 1'b0;
        we_a_reg_next = 1'b0;
        mux_sel_next  = 1'b0;
        start_next    = 1'b0;
        done_next     = 1'b0;
        busy_next     = (state_next != IDLE);

        case (state_next)
            IDLE: rst_plu_next = 1'b1;
            LOAD: begin
                eps_we_next   = 1'b1;
                we_prim_next  = 1'b1;
                we_a_reg_next = 1'b1;
                mux_sel_next  = 1'b1;
                rst_plu_next  = 1'b1;
            end
            ARM: start_next = 1'b1;
            UPDATE: begin
                we_a_reg_next = 1'b1;
                rst_plu_next  = 1'b1;
            end
            FIN: begin
                done_next    = 1'b1;
                rst_plu_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign rst_plu    = rst_plu_reg;
    assign eps_reg_we = eps_we_reg;
    assign we_prim    = we_prim_reg;
    assign we_a_reg   = we_a_reg_reg;
    assign mux_sel    = mux_sel_reg;
    assign start      = start_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign status     = status_reg;
    assign iter_count = iter_reg;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller: a small PLU/OutputCheck model answers the FSM,
// expected run results are queued by the stimulus and checked by a monitor on each done pulse.
module tb_maxnet_controller;

    localparam int MAX_ITER    = 4;
    localparam int ITER_W      = 7;
    localparam int PLU_TIMEOUT = 20;
    localparam int TMO_W       = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic              abort;
    logic              plu_done;
    logic              finish;
    logic              overflow;
    logic              rst_plu;
    logic              eps_reg_we;
    logic              we_prim;
    logic              we_a_reg;
    logic              mux_sel;
    logic              start;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [ITER_W-1:0] iter_count;

    maxnet_controller #(
        .MAX_ITER(MAX_ITER),
        .ITER_W(ITER_W),
        .PLU_TIMEOUT(PLU_TIMEOUT),
        .TMO_W(TMO_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .abort(abort),
        .plu_done(plu_done),
        .finish(finish),
        .overflow(overflow),
        .rst_plu(rst_plu),
        .eps_reg_we(eps_reg_we),
        .we_prim(we_prim),
        .we_a_reg(we_a_reg),
        .mux_sel(mux_sel),
        .start(start),
        .busy(busy),
        .done(done),
        .status(status),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // PLU model: done d cycles into WAIT_PLU; finish/overflow fire on a chosen round (0 = never).
    int   d_cfg;
    int   fin_round;
    int   ovf_round;
    logic plu_en;
    int   pcnt;
    int   rounds;

    always @(posedge clk) begin
        if (eps_reg_we) rounds <= 0;
        else if (start) rounds <= rounds + 1;
        if (rst_plu) pcnt <= 0;
        else if (start) pcnt <= 1;
        else if (pcnt != 0 && pcnt < d_cfg) pcnt <= pcnt + 1;
    end

    assign plu_done = plu_en && (pcnt == d_cfg);
    assign finish   = plu_done && (fin_round != 0) && (rounds == fin_round);
    assign overflow = plu_done && (ovf_round != 0) && (rounds == ovf_round);

    typedef struct {
        string name;
        int    status;
        int    iter;
        int    starts;
        int    loads;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    // Monitor: counts start/load pulses within a run and scores each done pulse.
    int starts_seen;
    int loads_seen;

    initial begin
        starts_seen = 0;
        loads_seen  = 0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                starts_seen = 0;
                loads_seen  = 0;
            end else begin
                if (start) starts_seen++;
                if (eps_reg_we) loads_seen++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_status"}, int'(status), e.status);
                    check({e.name, "_iter"}, int'(iter_count), e.iter);
                    check({e.name, "_starts"}, starts_seen, e.starts);
                    check({e.name, "_loads"}, loads_seen, e.loads);
                end
            end
        end
    end

    task automatic expect_run(input string name, input int st, input int it, input int sts);
        exp_t e;
        e.name   = name;
        e.status = st;
        e.iter   = it;
        e.starts = sts;
        e.loads  = 1;
        exp_q.push_back(e);
    endtask

    task automatic pulse_go();
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int start_cyc;
        rst       = 1'b0;
        go        = 1'b0;
        abort     = 1'b0;
        plu_en    = 1'b1;
        d_cfg     = 3;
        fin_round = 0;
        ovf_round = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rst_plu", int'(rst_plu), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_start", int'(start), 0);
        check("reset_status", int'(status), 0);
        check("reset_iter", int'(iter_count), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: winner on round 4 beats the iteration limit of 4; a go while busy must not restart
        d_cfg = 3; fin_round = 4; ovf_round = 0;
        expect_run("win", 0, 4, 4);
        pulse_go();
        repeat (6) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        wait_idle("win", 200);

        // 2: overflow together with plu_done on round 2
        d_cfg = 3; fin_round = 0; ovf_round = 2;
        expect_run("ovf", 1, 1, 2);
        pulse_go();
        wait_idle("ovf", 200);

        // 3: no winner -> iteration limit
        d_cfg = 2; fin_round = 0; ovf_round = 0;
        expect_run("iterlim", 2, 4, 4);
        pulse_go();
        wait_idle("iterlim", 200);

        // 4: plu_done never comes; status lands PLU_TIMEOUT+1 edges after the edge ending start
        plu_en = 1'b0;
        expect_run("tmo", 3, 0, 1);
        pulse_go();
        n = 0;
        while (!start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tmo_start_seen", int'(start), 1);
        start_cyc = 0;
        while (status != 2'b11 && start_cyc < 100) begin
            @(negedge clk);
            start_cyc++;
        end
        check("tmo_latency", start_cyc, PLU_TIMEOUT + 2);
        wait_idle("tmo", 200);
        plu_en = 1'b1;

        // 5: abort in WAIT_PLU of round 2, then a fresh run
        d_cfg = 5; fin_round = 0; ovf_round = 0;
        pulse_go();
        n = 0;
        while (rounds < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_iter_kept", int'(iter_count), 1);
        d_cfg = 3; fin_round = 1;
        expect_run("rerun", 0, 1, 1);
        pulse_go();
        check("rerun_load", int'(eps_reg_we), 1);
        check("rerun_iter_cleared", int'(iter_count), 0);
        wait_idle("rerun", 200);

        // 6: reset asserted during UPDATE
        d_cfg = 3; fin_round = 0;
        pulse_go();
        n = 0;
        while (!(we_a_reg && !mux_sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("upd_seen", int'(we_a_reg && !mux_sel), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_rst_plu", int'(rst_plu), 1);
        check("rst_mid_ctrl", int'({eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done}), 0);
        check("rst_mid_status", int'(status), 0);
        check("rst_mid_iter", int'(iter_count), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // go and abort together in IDLE: abort wins
        @(posedge clk);
        #1 begin go = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin go = 1'b0; abort = 1'b0; end
        check("go_abort_idle", int'(busy), 0);
        repeat (3) @(negedge clk);

        check("pending_done", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
